// File: rtl/mem_pkg.sv
// Shared constants and types for the load/store unit: RV32I load/store
// funct3 encodings, the LSU state encoding and the fixed MMIO addresses.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;
    localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check for one request: flags misaligned accesses
// and funct3 values that have no meaning for the request kind.
module lsu_align_check
    import mem_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_i,
    input  logic       is_fetch_i,
    output logic       err_o
);

    always_comb begin
        err_o = 1'b0;
        if (is_fetch_i) begin
            err_o = (addr_i != 2'b00);
        end else if (we_i) begin
            case (funct3_i)
                SB:      err_o = 1'b0;
                SH:      err_o = addr_i[0];
                SW:      err_o = (addr_i != 2'b00);
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB, LBU: err_o = 1'b0;
                LH, LHU: err_o = addr_i[0];
                LW:      err_o = (addr_i != 2'b00);
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Arbitrates a data port and a fetch port onto a single memory interface,
// one request at a time: accept -> ACCESS (memory cycle) -> RESP (pulse).
module load_store_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic        rsp_valid,
    output logic        rsp_src,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        write_mem,
    output logic [2:0]  funct3,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [31:0] read_address,
    input  logic [31:0] read_data,
    output lsu_state_t  dbg_state_o
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        src_q, src_d;
    logic        err_q, err_d;

    logic        can_accept;
    logic        acc_d, acc_i;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    // Data wins whenever it is valid; fetch only sees ready in a data-free cycle.
    always_comb begin
        can_accept = rst_n && (state_q == IDLE || state_q == RESP);
        d_ready    = can_accept;
        i_ready    = can_accept && !d_valid;
        acc_d      = d_valid && d_ready;
        acc_i      = i_valid && i_ready;
        if (acc_d) begin
            sel_we    = d_we;
            sel_f3    = d_funct3;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end else begin
            sel_we    = 1'b0;
            sel_f3    = LW;
            sel_addr  = i_addr;
            sel_wdata = 32'h0;
        end
    end

    lsu_align_check u_align (
        .we_i       (sel_we),
        .funct3_i   (sel_f3),
        .addr_i     (sel_addr[1:0]),
        .is_fetch_i (!acc_d),
        .err_o      (sel_err)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        src_d   = src_q;
        err_d   = err_q;
        case (state_q)
            IDLE, RESP: begin
                if (acc_d || acc_i) begin
                    state_d = ACCESS;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    f3_d    = sel_f3;
                    we_d    = sel_we;
                    src_d   = !acc_d;
                    err_d   = sel_err;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            f3_q    <= LW;
            we_q    <= 1'b0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst_n so a reset landing mid-transaction kills the write at once.
    always_comb begin
        write_mem     = 1'b0;
        funct3        = LW;
        write_address = 32'h0;
        write_data    = 32'h0;
        read_address  = 32'h0;
        rsp_valid     = 1'b0;
        rsp_src       = 1'b0;
        rsp_err       = 1'b0;
        rsp_rdata     = 32'h0;
        if (rst_n && state_q == ACCESS) begin
            write_mem     = we_q && !err_q;
            funct3        = f3_q;
            write_address = addr_q;
            write_data    = wdata_q;
            read_address  = addr_q;
        end
        if (rst_n && state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp_src   = src_q;
            rsp_err   = err_q;
            rsp_rdata = (!err_q && !we_q) ? read_data : 32'h0;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-level reference memory predicts
// every response and write; monitors pop expectations as the DUT produces them.
module tb_load_store_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid, d_ready, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        i_valid, i_ready;
    logic [31:0] i_addr;
    logic        rsp_valid, rsp_src, rsp_err;
    logic [31:0] rsp_rdata;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address, write_data, read_address;
    logic [31:0] read_data = 32'h0;
    lsu_state_t  dbg_state_o;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .write_mem(write_mem), .funct3(funct3), .write_address(write_address),
        .write_data(write_data), .read_address(read_address), .read_data(read_data),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Handshake: a request transfers at the rising edge where valid && ready.
    logic [65:0] exp_q[$];   // {cycle, src, err, rdata}
    logic [98:0] wr_q[$];    // {cycle, funct3, addr, data}
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory environment ----------------
    function automatic logic [31:0] env_rd(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w, s;
        w = env_mem.exists(a[31:2]) ? env_mem[a[31:2]] : 32'h0;
        s = w >> (8 * a[1:0]);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin : env
        logic [31:0] w;
        if (write_mem) begin
            w = env_mem.exists(write_address[31:2]) ? env_mem[write_address[31:2]] : 32'h0;
            case (funct3)
                3'b000: w[8*write_address[1:0] +: 8] = write_data[7:0];
                3'b001: w[8*write_address[1]*2 +: 16] = write_data[15:0];
                default: w = write_data;
            endcase
            env_mem[write_address[31:2]] = w;
        end
        read_data <= env_rd(read_address, funct3);
    end

    // ---------------- reference model ----------------
    function automatic bit legal(input bit fetch, input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (fetch) return (a % 4) == 0;
        if (we) begin
            if (f3 > 3'd2) return 1'b0;
        end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            return 1'b0;
        end
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_d(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int c);
        bit ok;
        logic [31:0] rd, c1, c2;
        ok = legal(1'b0, we, f3, a);
        c1 = c + 1;
        c2 = c + 2;
        rd = 32'h0;
        if (we && ok) begin
            for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a + i] = wd[8*i +: 8];
            wr_q.push_back({c1, f3, a, wd});
        end else if (!we && ok) begin
            rd = ref_load(f3, a);
        end
        exp_q.push_back({c2, 1'b0, !ok, rd});
    endtask

    task automatic model_i(input logic [31:0] a, input int c);
        bit ok;
        logic [31:0] c2;
        ok = legal(1'b1, 1'b0, 3'b010, a);
        c2 = c + 2;
        exp_q.push_back({c2, 1'b1, !ok, ok ? ref_load(3'b010, a) : 32'h0});
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [65:0] e;
        logic [98:0] w;
        if (mon_en) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL rsp_unexpected: got src=%0d err=%0d rdata=%h want no response", rsp_src, rsp_err, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e[65:34]);
                    check("rsp_src", rsp_src, e[33]);
                    check("rsp_err", rsp_err, e[32]);
                    check("rsp_rdata", rsp_rdata, e[31:0]);
                end
            end
            if (write_mem) begin
                if (wr_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h want no write", write_address, write_data);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", cyc, w[98:67]);
                    check("wr_funct3", funct3, w[66:64]);
                    check("wr_addr", write_address, w[63:32]);
                    check("wr_data", write_data, w[31:0]);
                end
            end
            if (dbg_state_o != ACCESS) begin
                check("idle_wmem", write_mem, 0);
                check("idle_funct3", funct3, 3'b010);
                check("idle_bus", read_address | write_address | write_data, 0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send_d(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        d_valid = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        n = 0;
        #1;
        while (!d_ready && n < 20) begin @(posedge clk); #2; n++; end
        if (!d_ready) begin
            checks++; errs++;
            $display("FAIL d_accept_timeout: got no d_ready want d_ready within 20 cycles");
            #4; d_valid = 1'b0; return;
        end
        model_d(we, f3, a, wd, cyc);
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic send_i(input logic [31:0] a);
        int n;
        i_valid = 1'b1; i_addr = a;
        n = 0;
        #1;
        while (!i_ready && n < 20) begin @(posedge clk); #2; n++; end
        if (!i_ready) begin
            checks++; errs++;
            $display("FAIL i_accept_timeout: got no i_ready want i_ready within 20 cycles");
            #4; i_valid = 1'b0; return;
        end
        model_i(a, cyc);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    // Both ports raised together: data must win, fetch follows two cycles later.
    task automatic send_pair(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] ia);
        int n, cd;
        d_valid = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        i_valid = 1'b1; i_addr = ia;
        n = 0;
        #1;
        while (!d_ready && n < 20) begin @(posedge clk); #2; n++; end
        check("pair_i_blocked", i_ready, 0);
        if (!d_ready) begin
            checks++; errs++;
            $display("FAIL pair_timeout: got no d_ready want d_ready within 20 cycles");
            #4; d_valid = 1'b0; i_valid = 1'b0; return;
        end
        cd = cyc;
        model_d(we, f3, a, wd, cyc);
        @(posedge clk); #1;
        d_valid = 1'b0;
        n = 0;
        #1;
        while (!i_ready && n < 20) begin @(posedge clk); #2; n++; end
        check("pair_fetch_gap", cyc - cd, 2);
        if (i_ready) model_i(ia, cyc);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF4 + 4 * $urandom_range(0, 2);
        else a = 4 * $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 0) a = a + $urandom_range(0, 3);
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        d_valid = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 0; d_wdata = 0;
        i_valid = 1'b1; i_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_d_ready", d_ready, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_src, rsp_err} | rsp_rdata, 0);
        check("rst_state", dbg_state_o, IDLE);
        d_valid = 1'b0; i_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        send_d(1'b1, SW, 32'h10, 32'hDEAD_BEEF);
        send_d(1'b0, LW, 32'h10, 32'h0);
        idle(2);
        send_d(1'b1, SW, 32'h10, 32'h80FF_0000);
        send_d(1'b0, LB, 32'h13, 32'h0);
        send_d(1'b0, LBU, 32'h13, 32'h0);
        idle(1);
        send_d(1'b0, LW, 32'h2, 32'h0);
        send_d(1'b1, SH, 32'h1, 32'h1234);
        idle(2);
        send_pair(1'b0, LW, 32'h10, 32'h0, 32'h0);
        idle(2);
        send_d(1'b1, SW, MMIO_LEDS, 32'h00FF_0000);
        send_d(1'b0, LW, MMIO_LEDS, 32'h0);
        idle(3);

        // Reset landing in ACCESS of a store: no write, no response.
        d_valid = 1'b1; d_we = 1'b1; d_funct3 = SW; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        #1;
        check("abort_accept", d_ready, 1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        check("abort_state_access", dbg_state_o, ACCESS);
        rst_n = 1'b0;
        #1;
        check("abort_wmem", write_mem, 0);
        check("abort_rsp", rsp_valid, 0);
        check("abort_ready", d_ready, 0);
        @(posedge clk); #1;
        check("abort_state_idle", dbg_state_o, IDLE);
        check("abort_outputs", {31'h0, rsp_valid} | read_address | write_data, 0);
        rst_n = 1'b1;
        idle(2);
        send_d(1'b0, LW, 32'h20, 32'h0);
        idle(2);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: send_d($urandom_range(0, 1), 3'($urandom_range(0, 7)), rand_addr(), $urandom);
                6, 7: send_i(rand_addr());
                8: send_pair($urandom_range(0, 1), 3'($urandom_range(0, 7)), rand_addr(), $urandom, rand_addr());
                default: idle($urandom_range(1, 3));
            endcase
        end

        idle(6);
        check("exp_q_drained", exp_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
